display_sequencer: RTL

Output controller for the processor's 4-digit decimal display. Two requesters share it: port 0 is the processor OUT path and port 1 is the debug/monitor path. It arbitrates between them round-robin, saturates the selected 32-bit value to 9999, and converts it to BCD with a sequential shift-and-add-3 (double-dabble) engine, which replaces the single-cycle divide/modulo chain. It drives the registered digit nibbles that feed the existing 7-segment `decode` instances.

---
 rtl/display_sequencer_pkg.sv | 21 ++
 rtl/display_sequencer_if.sv | 32 +++
 rtl/display_sequencer_bcd_dabble_step.sv | 28 ++
 rtl/display_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/display_sequencer_pkg.sv
// Shared types and defaults for the decimal display sequencer.
// Holds the FSM state encoding, width constants and the saturation helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int unsigned MAX_VAL_DEF   = 9999;
  localparam int unsigned CONV_BITS_DEF = 14;
  localparam int unsigned BCD_W         = 16;
  localparam int unsigned DIGIT_W       = 4;

  // Unsigned 32-bit clamp of a requested value to the display ceiling.
  function automatic logic [31:0] saturate(input logic [31:0] v, input logic [31:0] ceil_v);
    return (v > ceil_v) ? ceil_v : v;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Requester/display bundle of the display sequencer.
// Handshake: a requester raises reqN with a stable valN and holds both until
// gntN pulses for one cycle; that pulse means valN has been captured.
interface display_sequencer_if;
  import display_pkg::*;

  logic               req0;
  logic [31:0]        val0;
  logic               req1;
  logic [31:0]        val1;
  logic               clr;
  logic               gnt0;
  logic               gnt1;
  logic               busy;
  logic               done;
  logic               ovf;
  logic [DIGIT_W-1:0] milhares;
  logic [DIGIT_W-1:0] centenas;
  logic [DIGIT_W-1:0] dezenas;
  logic [DIGIT_W-1:0] unidades;

  modport master (
    output req0, val0, req1, val1, clr,
    input  gnt0, gnt1, busy, done, ovf, milhares, centenas, dezenas, unidades
  );

  modport slave (
    input  req0, val0, req1, val1, clr,
    output gnt0, gnt1, busy, done, ovf, milhares, centenas, dezenas, unidades
  );

endinterface

// File: rtl/display_sequencer_bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// {bcd, bin} left by one bit.
module bcd_dabble_step
  import display_pkg::*;
#(
  parameter int unsigned BIN_W = CONV_BITS_DEF
) (
  input  logic [BCD_W-1:0] bcd_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic [BIN_W-1:0] bin_o
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < int'(BCD_W / DIGIT_W); i++) begin
      if (bcd_i[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        adj[i*DIGIT_W +: DIGIT_W] = bcd_i[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
  end

  // The MSB of the adjusted accumulator falls off; it is always 0 for <= 14 input bits.
  assign {bcd_o, bin_o} = {adj, bin_i} << 1;

endmodule

// File: rtl/display_sequencer.sv
// Round-robin arbiter plus sequential binary-to-BCD converter driving the
// four registered display digits; one conversion every 16 cycles at most.
module display_sequencer
  import display_pkg::*;
#(
  parameter int unsigned MAX_VAL   = MAX_VAL_DEF,
  parameter int unsigned CONV_BITS = CONV_BITS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  display_sequencer_if.slave  bus,
  output state_e              state_dbg_o
);

  localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);

  state_e               state_q, state_d;
  logic [CONV_BITS-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_p_q, ovf_p_d;
  logic                 last_q, last_d;   // 1: port 1 was granted last
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic [BCD_W-1:0]     dig_q, dig_d;

  logic [BCD_W-1:0]     step_bcd;
  logic [CONV_BITS-1:0] step_bin;
  logic                 pick1;
  logic [31:0]          sel_val;

  bcd_dabble_step #(
    .BIN_W (CONV_BITS)
  ) u_step (
    .bcd_i (bcd_q),
    .bin_i (bin_q),
    .bcd_o (step_bcd),
    .bin_o (step_bin)
  );

  assign pick1   = bus.req1 & (~bus.req0 | ~last_q);
  assign sel_val = pick1 ? bus.val1 : bus.val0;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_p_d = ovf_p_q;
    last_d  = last_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    dig_d   = dig_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr) begin
          dig_d = '0;
          ovf_d = 1'b0;
        end else if (bus.req0 || bus.req1) begin
          bin_d   = CONV_BITS'(saturate(sel_val, MAX_VAL));
          ovf_p_d = (sel_val > MAX_VAL);
          bcd_d   = '0;
          cnt_d   = '0;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          last_d  = pick1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = step_bcd;
        bin_d = step_bin;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CONV_BITS - 1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        dig_d   = bcd_q;
        ovf_d   = ovf_p_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_p_q <= 1'b0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_p_q <= ovf_p_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.ovf      = ovf_q;
  assign bus.milhares = dig_q[15:12];
  assign bus.centenas = dig_q[11:8];
  assign bus.dezenas  = dig_q[7:4];
  assign bus.unidades = dig_q[3:0];
  assign state_dbg_o  = state_q;

endmodule
